// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and the Tuse value that marks an operand as unused.
package hazard_pkg;

    // D-stage forwarding select (per source operand)
    localparam logic [1:0] FWD_D_RF   = 2'd0;
    localparam logic [1:0] FWD_D_E    = 2'd1;
    localparam logic [1:0] FWD_D_M    = 2'd2;
    localparam logic [1:0] FWD_D_W    = 2'd3;

    // E-stage forwarding select (per source operand)
    localparam logic [1:0] FWD_E_PIPE = 2'd0;
    localparam logic [1:0] FWD_E_M    = 2'd1;
    localparam logic [1:0] FWD_E_W    = 2'd2;

    // M-stage store-data forwarding select
    localparam logic       FWD_M_PIPE = 1'b0;
    localparam logic       FWD_M_W    = 1'b1;

    localparam logic [1:0] TUSE_NONE  = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Multiply/divide busy timer: loads the unit latency on a start and counts
// down to zero, reporting busy while the count is nonzero.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int unsigned MAX_LAT = max_u(MULT_LAT, DIV_LAT);
    localparam int unsigned TW      = max_u(1, $clog2(MAX_LAT + 1));
    localparam logic [TW-1:0] MULT_V = TW'(MULT_LAT);
    localparam logic [TW-1:0] DIV_V  = TW'(DIV_LAT);

    logic [TW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start && !busy) begin
            cnt <= is_div ? DIV_V : MULT_V;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A start while busy is ignored; the MD stall should make it impossible.
    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline using pre-decoded
// Tuse/Tnew fields. Optional perf counters: define HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NSRC     = 2,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NSRC*REG_AW-1:0]   d_src_addr,
    input  logic [NSRC*2-1:0]        d_tuse,
    input  logic                     d_is_md,
    input  logic [NSRC*REG_AW-1:0]   e_src_addr,
    input  logic [REG_AW-1:0]        m_src_addr,
    input  logic [REG_AW-1:0]        e_wr_addr,
    input  logic [REG_AW-1:0]        m_wr_addr,
    input  logic [REG_AW-1:0]        w_wr_addr,
    input  logic [1:0]               e_tnew,
    input  logic [1:0]               m_tnew,
    input  logic                     e_md_start,
    input  logic                     e_md_is_div,
    output logic                     stall,
    output logic [NSRC*2-1:0]        d_fwd_sel,
    output logic [NSRC*2-1:0]        e_fwd_sel,
    output logic                     m_fwd_sel,
    output logic                     md_busy,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         md_stall_cnt
);

    // Register 0 is hard-wired zero, so it never matches a producer.
    function automatic logic hit(input logic [REG_AW-1:0] wr, input logic [REG_AW-1:0] src);
        return (src != '0) && (wr == src);
    endfunction

    logic data_stall;
    logic md_stall;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        data_stall = 1'b0;
        d_fwd_sel  = '0;
        e_fwd_sel  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (d_tuse[i*2 +: 2] != TUSE_NONE &&
                ((hit(e_wr_addr, d_src_addr[i*REG_AW +: REG_AW]) && e_tnew > d_tuse[i*2 +: 2]) ||
                 (hit(m_wr_addr, d_src_addr[i*REG_AW +: REG_AW]) && m_tnew > d_tuse[i*2 +: 2])))
                data_stall = 1'b1;

            // Nearest producer wins, even while stalling.
            if (hit(e_wr_addr, d_src_addr[i*REG_AW +: REG_AW]) && e_tnew == 2'd0)
                d_fwd_sel[i*2 +: 2] = FWD_D_E;
            else if (hit(m_wr_addr, d_src_addr[i*REG_AW +: REG_AW]) && m_tnew == 2'd0)
                d_fwd_sel[i*2 +: 2] = FWD_D_M;
            else if (hit(w_wr_addr, d_src_addr[i*REG_AW +: REG_AW]))
                d_fwd_sel[i*2 +: 2] = FWD_D_W;
            else
                d_fwd_sel[i*2 +: 2] = FWD_D_RF;

            if (hit(m_wr_addr, e_src_addr[i*REG_AW +: REG_AW]) && m_tnew == 2'd0)
                e_fwd_sel[i*2 +: 2] = FWD_E_M;
            else if (hit(w_wr_addr, e_src_addr[i*REG_AW +: REG_AW]))
                e_fwd_sel[i*2 +: 2] = FWD_E_W;
            else
                e_fwd_sel[i*2 +: 2] = FWD_E_PIPE;
        end
    end

    assign m_fwd_sel = hit(w_wr_addr, m_src_addr) ? FWD_M_W : FWD_M_PIPE;
    assign md_stall  = d_is_md && (md_busy || e_md_start);
    assign stall     = data_stall || md_stall;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk    (clk),
        .rst_n  (reset),
        .start  (e_md_start),
        .is_div (e_md_is_div),
        .busy   (md_busy)
    );

`ifdef HAZARD_PERF_EN
    // Saturating counters: they stick at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            md_stall_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (md_stall && md_stall_cnt != '1)
                md_stall_cnt <= md_stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt    = '0;
    assign md_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; perf-counter expectations
// switch on HAZARD_PERF_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  d_src_addr;
    logic [3:0]  d_tuse;
    logic        d_is_md;
    logic [9:0]  e_src_addr;
    logic [4:0]  m_src_addr;
    logic [4:0]  e_wr_addr, m_wr_addr, w_wr_addr;
    logic [1:0]  e_tnew, m_tnew;
    logic        e_md_start, e_md_is_div;
    logic        stall;
    logic [3:0]  d_fwd_sel, e_fwd_sel;
    logic        m_fwd_sel;
    logic        md_busy;
    logic [15:0] stall_cnt, md_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .d_src_addr   (d_src_addr),
        .d_tuse       (d_tuse),
        .d_is_md      (d_is_md),
        .e_src_addr   (e_src_addr),
        .m_src_addr   (m_src_addr),
        .e_wr_addr    (e_wr_addr),
        .m_wr_addr    (m_wr_addr),
        .w_wr_addr    (w_wr_addr),
        .e_tnew       (e_tnew),
        .m_tnew       (m_tnew),
        .e_md_start   (e_md_start),
        .e_md_is_div  (e_md_is_div),
        .stall        (stall),
        .d_fwd_sel    (d_fwd_sel),
        .e_fwd_sel    (e_fwd_sel),
        .m_fwd_sel    (m_fwd_sel),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt),
        .md_stall_cnt (md_stall_cnt)
    );

`ifdef HAZARD_PERF_EN
    logic       s_stall, s_m_fwd, s_busy;
    logic [3:0] s_d_fwd, s_e_fwd;
    logic [2:0] s_stall_cnt, s_md_stall_cnt;

    hazard_ctrl #(.CNT_W(3)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .d_src_addr   (d_src_addr),
        .d_tuse       (d_tuse),
        .d_is_md      (d_is_md),
        .e_src_addr   (e_src_addr),
        .m_src_addr   (m_src_addr),
        .e_wr_addr    (e_wr_addr),
        .m_wr_addr    (m_wr_addr),
        .w_wr_addr    (w_wr_addr),
        .e_tnew       (e_tnew),
        .m_tnew       (m_tnew),
        .e_md_start   (e_md_start),
        .e_md_is_div  (e_md_is_div),
        .stall        (s_stall),
        .d_fwd_sel    (s_d_fwd),
        .e_fwd_sel    (s_e_fwd),
        .m_fwd_sel    (s_m_fwd),
        .md_busy      (s_busy),
        .stall_cnt    (s_stall_cnt),
        .md_stall_cnt (s_md_stall_cnt)
    );
`endif

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        d_src_addr  = '0;
        d_tuse      = {2'd3, 2'd3};
        d_is_md     = 1'b0;
        e_src_addr  = '0;
        m_src_addr  = '0;
        e_wr_addr   = '0;
        m_wr_addr   = '0;
        w_wr_addr   = '0;
        e_tnew      = '0;
        m_tnew      = '0;
        e_md_start  = 1'b0;
        e_md_is_div = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // One load-use data stall for the current cycle: E produces r8 in 2, D needs it in 1.
    task automatic set_load_use();
        clear_inputs();
        e_wr_addr  = 5'd8;
        e_tnew     = 2'd2;
        d_src_addr = {5'd0, 5'd8};
        d_tuse     = {2'd3, 2'd1};
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #12;
        check("reset_busy",     32'(md_busy), 0);
        check("reset_stall",    32'(stall), 0);
        check("reset_cnt",      32'(stall_cnt), 0);
        check("reset_md_cnt",   32'(md_stall_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        // Load-use stall, then drain through M
        @(negedge clk);
        set_load_use();
        #1;
        check("lu_stall", 32'(stall), 1);
        check("lu_dfwd0", 32'(d_fwd_sel[1:0]), 0);
        @(negedge clk);
        clear_inputs();
        m_wr_addr  = 5'd8;
        m_tnew     = 2'd1;
        d_src_addr = {5'd0, 5'd8};
        d_tuse     = {2'd3, 2'd1};
        #1;
        check("lu_m1_stall", 32'(stall), 0);
        check("lu_m1_dfwd0", 32'(d_fwd_sel[1:0]), 0);
        @(negedge clk);
        m_tnew = 2'd0;
        #1;
        check("lu_m0_stall", 32'(stall), 0);
        check("lu_m0_dfwd0", 32'(d_fwd_sel[1:0]), 2);

        // Priority: E beats M beats W
        @(negedge clk);
        clear_inputs();
        e_wr_addr  = 5'd9;
        m_wr_addr  = 5'd9;
        w_wr_addr  = 5'd9;
        d_src_addr = {5'd9, 5'd0};
        d_tuse     = {2'd0, 2'd3};
        e_src_addr = {5'd9, 5'd0};
        m_src_addr = 5'd9;
        #1;
        check("pri_stall", 32'(stall), 0);
        check("pri_dfwd1", 32'(d_fwd_sel[3:2]), 1);
        check("pri_dfwd0", 32'(d_fwd_sel[1:0]), 0);
        check("pri_efwd1", 32'(e_fwd_sel[3:2]), 1);
        check("pri_mfwd",  32'(m_fwd_sel), 1);

        // Zero register never hazards nor forwards
        @(negedge clk);
        clear_inputs();
        e_tnew = 2'd2;
        m_tnew = 2'd2;
        d_tuse = {2'd0, 2'd0};
        #1;
        check("zero_stall", 32'(stall), 0);
        check("zero_dfwd",  32'(d_fwd_sel), 0);
        check("zero_efwd",  32'(e_fwd_sel), 0);
        check("zero_mfwd",  32'(m_fwd_sel), 0);

        // E and M both match, E stalls: stall still reports, select picks M
        @(negedge clk);
        clear_inputs();
        e_wr_addr  = 5'd5;
        m_wr_addr  = 5'd5;
        e_tnew     = 2'd2;
        d_src_addr = {5'd0, 5'd5};
        d_tuse     = {2'd3, 2'd0};
        #1;
        check("em_stall", 32'(stall), 1);
        check("em_dfwd0", 32'(d_fwd_sel[1:0]), 2);

        // W-only match never stalls
        @(negedge clk);
        clear_inputs();
        w_wr_addr  = 5'd6;
        d_src_addr = {5'd0, 5'd6};
        d_tuse     = {2'd3, 2'd0};
        e_src_addr = {5'd6, 5'd0};
        #1;
        check("w_stall", 32'(stall), 0);
        check("w_dfwd0", 32'(d_fwd_sel[1:0]), 3);
        check("w_efwd1", 32'(e_fwd_sel[3:2]), 2);

        // Unused operand (Tuse 3) never stalls
        @(negedge clk);
        set_load_use();
        d_tuse = {2'd3, 2'd3};
        #1;
        check("unused_stall", 32'(stall), 0);

        // Divide: busy cycles 1..10, MD stall cycles 0..10
        @(negedge clk);
        clear_inputs();
        e_md_start  = 1'b1;
        e_md_is_div = 1'b1;
        d_is_md     = 1'b1;
        #1;
        check("div_c0_stall", 32'(stall), 1);
        check("div_c0_busy",  32'(md_busy), 0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            e_md_start = 1'b0;
            #1;
            check($sformatf("div_c%0d_busy", c),  32'(md_busy), 1);
            check($sformatf("div_c%0d_stall", c), 32'(stall), 1);
        end
        @(negedge clk);
        #1;
        check("div_c11_busy",  32'(md_busy), 0);
        check("div_c11_stall", 32'(stall), 0);

        // Reset in the middle of a multiply
        @(negedge clk);
        clear_inputs();
        e_md_start = 1'b1;
        @(negedge clk);
        e_md_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mid_busy_before", 32'(md_busy), 1);
        reset = 1'b0;
        #1;
        check("rst_mid_busy_now", 32'(md_busy), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_busy_rel", 32'(md_busy), 0);
        @(negedge clk);
        #1;
        check("rst_mid_busy_later", 32'(md_busy), 0);

        // Perf counters: 4 MD stall cycles + 3 data stall cycles, then 2 more
        pulse_reset();
        @(negedge clk);
        clear_inputs();
        e_md_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            clear_inputs();
            d_is_md = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clear_inputs();
        end
        check("perf_md_idle", 32'(md_busy), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_load_use();
        end
        @(negedge clk);
        clear_inputs();
        #1;
`ifdef HAZARD_PERF_EN
        check("perf_stall_cnt",    32'(stall_cnt), 7);
        check("perf_md_stall_cnt", 32'(md_stall_cnt), 4);
        check("perf_sat_cnt7",     32'(s_stall_cnt), 7);
`else
        check("perf_stall_cnt",    32'(stall_cnt), 0);
        check("perf_md_stall_cnt", 32'(md_stall_cnt), 0);
`endif
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            set_load_use();
        end
        @(negedge clk);
        clear_inputs();
        #1;
`ifdef HAZARD_PERF_EN
        check("perf_stall_cnt9",  32'(stall_cnt), 9);
        check("perf_sat_cnt9",    32'(s_stall_cnt), 7);
        check("perf_sat_md_cnt",  32'(s_md_stall_cnt), 4);
`else
        check("perf_stall_cnt9",  32'(stall_cnt), 0);
`endif
        pulse_reset();
        #1;
        check("perf_cnt_cleared", 32'(stall_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
